adder_operand_streamer: RTL

- Datapath-side partner of the chunked adder controller.
- Accepts two WIDTH-bit operands through a valid/ready handshake and slices them into CHUNK_W-bit chunks, least significant first. It presents one chunk pair per controller load strobe (chunk_req).
- Collects one sum chunk per controller store strobe (sum_valid) and reassembles the WIDTH-bit sum plus carry-out. The result is returned through a second valid/ready handshake.

---
 rtl/adder_operand_streamer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/adder_operand_streamer.sv
// rtl/adder_operand_streamer.sv - slices operands into chunks for the chunked adder and reassembles the sum
module adder_operand_streamer #(
  parameter int WIDTH   = 381,
  parameter int CHUNK_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               chunk_req,
  output logic [CHUNK_W-1:0] a_chunk,
  output logic [CHUNK_W-1:0] b_chunk,
  output logic               chunk_last,
  input  logic               sum_valid,
  input  logic [CHUNK_W-1:0] sum_chunk,
  input  logic               carry_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   sum_out,
  output logic               carry_out,
  output logic               busy,
  output logic               err
);

  localparam int NCHUNK    = (WIDTH + CHUNK_W - 1) / CHUNK_W;
  localparam int PAD_W     = NCHUNK * CHUNK_W;
  localparam int IDX_W     = $clog2(NCHUNK + 1);
  localparam int LAST_W    = WIDTH - (NCHUNK - 1) * CHUNK_W;
  localparam bit HAS_PAD   = (PAD_W > WIDTH);
  localparam int CARRY_BIT = HAS_PAD ? LAST_W : 0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
  localparam logic [IDX_W-1:0] END_IDX  = IDX_W'(NCHUNK);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    HOLD
  } state_t;

  state_t state, state_next;

  logic [PAD_W-1:0] a_sr, b_sr;
  logic [PAD_W-1:0] a_pad, b_pad;
  logic [PAD_W-1:0] a_next, b_next;
  logic [IDX_W-1:0] rd_idx, wr_idx;

  logic accept;
  logic advance;
  logic sum_wr;
  logic last_wr;
  logic proto_err;

  assign a_pad  = PAD_W'(a_in);
  assign b_pad  = PAD_W'(b_in);
  assign a_next = a_sr >> CHUNK_W;
  assign b_next = b_sr >> CHUNK_W;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    advance    = 1'b0;
    sum_wr     = 1'b0;
    last_wr    = 1'b0;
    proto_err  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept     = 1'b1;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (chunk_req) begin
          if (rd_idx < END_IDX) advance = 1'b1;
          else                  proto_err = 1'b1;
        end
        // Compared against rd_idx before this cycle's advance, so a sum can
        // never be credited to the chunk being requested in the same cycle.
        if (sum_valid) begin
          if (wr_idx < rd_idx) begin
            sum_wr = 1'b1;
            if (wr_idx == LAST_IDX) begin
              last_wr    = 1'b1;
              state_next = HOLD;
            end
          end else begin
            proto_err = 1'b1;
          end
        end
      end
      HOLD: begin
        if (chunk_req || sum_valid) proto_err = 1'b1;
        if (out_valid && out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      chunk_last <= 1'b0;
      a_chunk    <= '0;
      b_chunk    <= '0;
      a_sr       <= '0;
      b_sr       <= '0;
      rd_idx     <= '0;
      wr_idx     <= '0;
      sum_out    <= '0;
      carry_out  <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == HOLD);
      busy      <= (state_next != IDLE);

      if (accept)         err <= 1'b0;
      else if (proto_err) err <= 1'b1;

      if (accept) begin
        a_sr       <= a_pad;
        b_sr       <= b_pad;
        a_chunk    <= a_pad[CHUNK_W-1:0];
        b_chunk    <= b_pad[CHUNK_W-1:0];
        chunk_last <= (NCHUNK == 1);
        rd_idx     <= '0;
        wr_idx     <= '0;
        sum_out    <= '0;
        carry_out  <= 1'b0;
      end else begin
        if (advance) begin
          a_sr       <= a_next;
          b_sr       <= b_next;
          a_chunk    <= a_next[CHUNK_W-1:0];
          b_chunk    <= b_next[CHUNK_W-1:0];
          chunk_last <= ((rd_idx + IDX_W'(1)) == LAST_IDX);
          rd_idx     <= rd_idx + IDX_W'(1);
        end
        if (sum_wr) begin
          wr_idx <= wr_idx + IDX_W'(1);
          for (int i = 0; i < NCHUNK - 1; i++) begin
            if (wr_idx == IDX_W'(i)) sum_out[i*CHUNK_W +: CHUNK_W] <= sum_chunk;
          end
          // The top chunk only partly fits; its first padding bit is the carry.
          if (last_wr) begin
            sum_out[(NCHUNK-1)*CHUNK_W +: LAST_W] <= sum_chunk[LAST_W-1:0];
            carry_out <= HAS_PAD ? sum_chunk[CARRY_BIT] : carry_in;
          end
        end
      end
    end
  end

endmodule
